// File: rtl/sram_bank_arb.sv
// Per-bank SRAM arbiter: round-robin across clients with read/write alternation,
// a registered single-beat command stage and a tagged read-return pipe.
module sram_bank_arb #(
   parameter int         NUM_REQ = 16,
   parameter int         ADDR_W  = 19,
   parameter int         DATA_W  = 256,
   parameter logic [3:0] BANK_ID = 4'd0,
   parameter int         RD_LAT  = 1
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               en,
   input  logic [NUM_REQ-1:0]                 req,
   input  logic [NUM_REQ-1:0]                 req_we,
   input  logic [NUM_REQ-1:0][ADDR_W-1:0]     req_addr,
   input  logic [NUM_REQ-1:0][DATA_W-1:0]     req_wdata,
   output logic [NUM_REQ-1:0]                 gnt,
   output logic                               sram_cs,
   output logic                               sram_we,
   output logic [9:0]                         sram_addr,
   output logic [DATA_W-1:0]                  sram_wdata,
   input  logic [DATA_W-1:0]                  sram_rdata,
   output logic                               rd_valid,
   output logic [$clog2(NUM_REQ)-1:0]         rd_id,
   output logic [DATA_W-1:0]                  rd_data,
   output logic                               addr_err
);
   localparam int IDW = $clog2(NUM_REQ);

   logic [IDW-1:0]     rr_ptr;
   logic               last_wr;
   logic [IDW-1:0]     cmd_id;
   logic [RD_LAT-1:0]  vld_pipe;
   logic [IDW-1:0]     id_pipe [RD_LAT];

   logic [NUM_REQ-1:0] rd_mask;
   logic [NUM_REQ-1:0] wr_mask;
   logic [NUM_REQ-1:0] cand;
   logic [IDW-1:0]     sel;
   logic [IDW-1:0]     idx;
   logic               pick_wr;
   logic               found;
   logic               grant;
   logic               bank_ok;

   // Type choice alternates only when both kinds are pending; then a
   // rotating priority scan starting at rr_ptr picks the client.
   always_comb begin
      rd_mask = req & ~req_we;
      wr_mask = req & req_we;
      pick_wr = (|rd_mask && |wr_mask) ? ~last_wr : |wr_mask;
      cand    = pick_wr ? wr_mask : rd_mask;
      found   = 1'b0;
      sel     = '0;
      idx     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = rr_ptr + IDW'(k);
         if (!found && cand[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
      grant   = en & found;
      gnt     = grant ? (NUM_REQ'(1) << sel) : '0;
      bank_ok = ({req_addr[sel][18:16], req_addr[sel][5]} == BANK_ID);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr     <= '0;
         last_wr    <= 1'b1;
         sram_cs    <= 1'b0;
         sram_we    <= 1'b0;
         sram_addr  <= '0;
         sram_wdata <= '0;
         addr_err   <= 1'b0;
         cmd_id     <= '0;
         vld_pipe   <= '0;
         for (int s = 0; s < RD_LAT; s++) id_pipe[s] <= '0;
         rd_valid   <= 1'b0;
         rd_id      <= '0;
         rd_data    <= '0;
      end else begin
         // A mis-addressed grant is consumed but never reaches the bank.
         sram_cs  <= grant & bank_ok;
         sram_we  <= grant & bank_ok & req_we[sel];
         addr_err <= grant & ~bank_ok;
         if (grant) begin
            rr_ptr     <= sel + IDW'(1);
            last_wr    <= req_we[sel];
            sram_addr  <= req_addr[sel][15:6];
            sram_wdata <= req_wdata[sel];
            cmd_id     <= sel;
         end
         vld_pipe[0] <= sram_cs & ~sram_we;
         id_pipe[0]  <= cmd_id;
         for (int s = 1; s < RD_LAT; s++) begin
            vld_pipe[s] <= vld_pipe[s-1];
            id_pipe[s]  <= id_pipe[s-1];
         end
         // Last pipe stage lines up with the cycle sram_rdata is valid.
         rd_valid <= vld_pipe[RD_LAT-1];
         if (vld_pipe[RD_LAT-1]) begin
            rd_id   <= id_pipe[RD_LAT-1];
            rd_data <= sram_rdata;
         end
      end
   end
endmodule

// File: tb/tb_sram_bank_arb.sv
// Bench for sram_bank_arb: arbitration reference model, SRAM model and a
// read-return scoreboard, driven by directed and randomized scenarios.
module tb_sram_bank_arb;
   localparam int         RD_LAT = 1;
   localparam logic [3:0] BANK   = 4'd5;

   logic               clk = 1'b0;
   logic               rst;
   logic               en;
   logic [15:0]        req;
   logic [15:0]        req_we;
   logic [15:0][18:0]  req_addr;
   logic [15:0][255:0] req_wdata;
   logic [15:0]        gnt;
   logic               sram_cs;
   logic               sram_we;
   logic [9:0]         sram_addr;
   logic [255:0]       sram_wdata;
   logic [255:0]       sram_rdata;
   logic               rd_valid;
   logic [3:0]         rd_id;
   logic [255:0]       rd_data;
   logic               addr_err;

   sram_bank_arb #(.NUM_REQ(16), .ADDR_W(19), .DATA_W(256), .BANK_ID(BANK), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst(rst), .en(en), .req(req), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .gnt(gnt), .sram_cs(sram_cs), .sram_we(sram_we),
      .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
      .rd_valid(rd_valid), .rd_id(rd_id), .rd_data(rd_data), .addr_err(addr_err)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   int cyc;
   always @(posedge clk) cyc <= cyc + 1;

   int compared;
   int mismatched;

   function automatic logic [255:0] init_word(input int w);
      logic [255:0] d;
      for (int j = 0; j < 8; j++) d[j*32 +: 32] = 32'(w * 8 + j) * 32'h9E3779B1 ^ 32'h5A5A0000;
      return d;
   endfunction

   function automatic logic [18:0] mk_addr(input logic [3:0] bank, input logic [9:0] word, input logic [4:0] low);
      return {bank[3:1], word, bank[0], low};
   endfunction

   // SRAM model: fixed latency, contents persist across arbiter reset
   logic [255:0] mem [1024];
   bit           mem_wr [1024];
   logic [255:0] rdp [RD_LAT];
   always @(posedge clk) begin
      if (sram_cs && sram_we) begin
         mem[sram_addr]    <= sram_wdata;
         mem_wr[sram_addr] <= 1'b1;
      end
      rdp[0] <= (sram_cs && !sram_we) ? (mem_wr[sram_addr] ? mem[sram_addr] : init_word(int'(sram_addr)))
                                      : {8{$urandom}};
      for (int k = 1; k < RD_LAT; k++) rdp[k] <= rdp[k-1];
   end
   assign sram_rdata = rdp[RD_LAT-1];

   // reference model state
   int           rr_m;
   bit           last_w_m;
   logic [255:0] ref_mem [1024];
   bit           ref_wr [1024];

   typedef struct packed {
      logic [3:0]   id;
      logic [255:0] data;
      logic [31:0]  due;
   } rd_t;
   rd_t exp_q[$];

   bit           ec_valid;
   bit           ec_cs, ec_err, ec_we;
   logic [9:0]   ec_addr;
   logic [255:0] ec_wdata;

   function automatic int ref_pick();
      logic [15:0] r_m, w_m, c;
      bit use_w;
      if (!en || req == 16'h0) return -1;
      r_m = req & ~req_we;
      w_m = req & req_we;
      use_w = (r_m != 0 && w_m != 0) ? !last_w_m : (w_m != 0);
      c = use_w ? w_m : r_m;
      for (int k = 0; k < 16; k++) if (c[(rr_m + k) % 16]) return (rr_m + k) % 16;
      return -1;
   endfunction

   // driver: called at posedge+1 with inputs set; returns at next posedge+1
   task automatic run_cycle(output logic [15:0] g_obs, output int p);
      logic [18:0] a;
      logic [9:0]  word;
      rd_t         e;
      #3;
      p = ref_pick();
      g_obs = gnt;
      @(posedge clk);
      ec_valid = 1'b1; ec_cs = 1'b0; ec_err = 1'b0; ec_we = 1'b0; ec_addr = '0; ec_wdata = '0;
      if (p >= 0) begin
         a = req_addr[p];
         word = a[15:6];
         rr_m = (p + 1) % 16;
         last_w_m = req_we[p];
         ec_cs = ({a[18:16], a[5]} == BANK);
         ec_err = !ec_cs;
         ec_we = req_we[p]; ec_addr = word; ec_wdata = req_wdata[p];
         if (ec_cs && req_we[p]) begin
            ref_mem[word] = req_wdata[p];
            ref_wr[word] = 1'b1;
         end else if (ec_cs) begin
            e.id = 4'(p);
            e.data = ref_wr[word] ? ref_mem[word] : init_word(int'(word));
            e.due = 32'(cyc + 2 + RD_LAT);
            exp_q.push_back(e);
         end
      end
      #1;
   endtask

   task automatic set_idle();
      req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
   endtask

   task automatic drain(input int n);
      logic [15:0] g;
      int p;
      set_idle();
      repeat (n) run_cycle(g, p);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      ec_valid = 1'b0;
      exp_q.delete();
      rr_m = 0;
      last_w_m = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // scoreboard: command stage and read returns
   always @(negedge clk) begin
      rd_t e;
      if (!rst) begin
         if (ec_valid) begin
            compared++;
            if (sram_cs !== ec_cs || addr_err !== ec_err) begin
               mismatched++;
               $display("FAIL cmd_ctl cyc=%0d cs=%b err=%b expected cs=%b err=%b", cyc, sram_cs, addr_err, ec_cs, ec_err);
            end
            if (ec_cs) begin
               compared++;
               if (sram_we !== ec_we || sram_addr !== ec_addr || sram_wdata !== ec_wdata) begin
                  mismatched++;
                  $display("FAIL cmd_fields cyc=%0d we=%b addr=%h wdata=%h expected we=%b addr=%h wdata=%h",
                           cyc, sram_we, sram_addr, sram_wdata, ec_we, ec_addr, ec_wdata);
               end
            end
         end
         if (rd_valid === 1'b1) begin
            compared++;
            if (exp_q.size() == 0) begin
               mismatched++;
               $display("FAIL rd_unexpected cyc=%0d rd_id=%0d expected no return", cyc, rd_id);
            end else begin
               e = exp_q.pop_front();
               if (rd_id !== e.id || rd_data !== e.data || 32'(cyc) != e.due) begin
                  mismatched++;
                  $display("FAIL rd_return cyc=%0d id=%0d data=%h expected cyc=%0d id=%0d data=%h",
                           cyc, rd_id, rd_data, e.due, e.id, e.data);
               end
            end
         end else if (exp_q.size() > 0 && 32'(cyc) >= exp_q[0].due) begin
            compared++;
            mismatched++;
            $display("FAIL rd_missing cyc=%0d rd_valid=%b expected id=%0d", cyc, rd_valid, exp_q[0].id);
            void'(exp_q.pop_front());
         end
      end
   end

   task automatic test_reset();
      rst = 1'b1; en = 1'b1;
      set_idle();
      repeat (2) @(posedge clk);
      #1;
      compared++;
      if ({gnt, sram_cs, sram_we, addr_err, rd_valid} !== 20'h0) begin
         mismatched++;
         $display("FAIL reset_ctl gnt=%h cs=%b we=%b err=%b rv=%b expected all 0", gnt, sram_cs, sram_we, addr_err, rd_valid);
      end
      compared++;
      if (sram_addr !== 10'h0 || sram_wdata !== '0 || rd_id !== 4'h0 || rd_data !== '0) begin
         mismatched++;
         $display("FAIL reset_data addr=%h id=%0d expected 0", sram_addr, rd_id);
      end
      rr_m = 0; last_w_m = 1'b1;
      rst = 1'b0;
   endtask

   task automatic test_first_read();
      logic [15:0] g;
      int p;
      set_idle();
      req[3] = 1'b1;
      req_addr[3] = mk_addr(BANK, 10'h012, 5'h0);
      req_wdata[3] = {8{$urandom}};
      run_cycle(g, p);
      compared++;
      if (g !== 16'h0008) begin mismatched++; $display("FAIL first_gnt gnt=%h expected 0008", g); end
      set_idle();
      compared++;
      if (sram_cs !== 1'b1 || sram_we !== 1'b0 || sram_addr !== 10'h012) begin
         mismatched++;
         $display("FAIL first_cmd cs=%b we=%b addr=%h expected 1 0 012", sram_cs, sram_we, sram_addr);
      end
      run_cycle(g, p);
      run_cycle(g, p);
      compared++;
      if (rd_valid !== 1'b1 || rd_id !== 4'd3 || rd_data !== init_word(12'h012)) begin
         mismatched++;
         $display("FAIL first_ret rv=%b id=%0d data=%h expected 1 3 %h", rd_valid, rd_id, rd_data, init_word(12'h012));
      end
      drain(4);
   endtask

   task automatic test_all_reads();
      logic [15:0] g;
      int p;
      int cnt[16];
      do_reset();
      for (int i = 0; i < 16; i++) cnt[i] = 0;
      for (int k = 0; k < 32; k++) begin
         req = 16'hFFFF; req_we = '0;
         for (int i = 0; i < 16; i++) begin
            req_addr[i] = mk_addr(BANK, 10'($urandom_range(0, 63)), 5'($urandom_range(0, 31)));
            req_wdata[i] = {8{$urandom}};
         end
         run_cycle(g, p);
         compared++;
         if (g !== (16'h1 << (k % 16))) begin
            mismatched++;
            $display("FAIL rr_order k=%0d gnt=%h expected %h", k, g, 16'h1 << (k % 16));
         end
         for (int i = 0; i < 16; i++) if (g[i]) cnt[i]++;
      end
      for (int i = 0; i < 16; i++) begin
         compared++;
         if (cnt[i] != 2) begin mismatched++; $display("FAIL rr_count client=%0d grants=%0d expected 2", i, cnt[i]); end
      end
      drain(5);
   endtask

   task automatic test_alternation();
      logic [15:0] g;
      int p;
      int seq[8] = '{2, 4, 5, 4, 5, 4, 5, 4};
      do_reset();
      for (int k = 0; k < 8; k++) begin
         set_idle();
         req = 16'h0034; req_we = 16'h0010;
         for (int i = 2; i < 6; i++) begin
            req_addr[i] = mk_addr(BANK, 10'($urandom_range(0, 1023)), 5'h0);
            req_wdata[i] = {8{$urandom}};
         end
         run_cycle(g, p);
         compared++;
         if (g !== (16'h1 << seq[k])) begin
            mismatched++;
            $display("FAIL alt_order k=%0d gnt=%h expected %h", k, g, 16'h1 << seq[k]);
         end
      end
      drain(5);
   endtask

   task automatic test_bank_mismatch();
      logic [15:0] g;
      int p;
      for (int t = 0; t < 2; t++) begin
         set_idle();
         req[7] = 1'b1; req_we[7] = (t == 0);
         req_addr[7] = mk_addr(BANK ^ 4'h1, 10'h2A5, 5'h3);
         req_wdata[7] = {8{$urandom}};
         run_cycle(g, p);
         compared++;
         if (g !== 16'h0080) begin mismatched++; $display("FAIL mis_gnt t=%0d gnt=%h expected 0080", t, g); end
         set_idle();
         compared++;
         if (sram_cs !== 1'b0 || addr_err !== 1'b1) begin
            mismatched++;
            $display("FAIL mis_cmd t=%0d cs=%b err=%b expected 0 1", t, sram_cs, addr_err);
         end
         run_cycle(g, p);
         compared++;
         if (addr_err !== 1'b0) begin mismatched++; $display("FAIL mis_pulse t=%0d err=%b expected 0", t, addr_err); end
      end
      drain(5);
   endtask

   task automatic test_reset_mid();
      logic [15:0] g;
      int p;
      set_idle();
      req[1] = 1'b1; req_addr[1] = mk_addr(BANK, 10'h001, 5'h0);
      run_cycle(g, p);
      compared++;
      if (g !== 16'h0002) begin mismatched++; $display("FAIL mid_g1 gnt=%h expected 0002", g); end
      set_idle();
      req[9] = 1'b1; req_addr[9] = mk_addr(BANK, 10'h009, 5'h0);
      run_cycle(g, p);
      compared++;
      if (g !== 16'h0200) begin mismatched++; $display("FAIL mid_g9 gnt=%h expected 0200", g); end
      set_idle();
      rst = 1'b1;
      ec_valid = 1'b0;
      exp_q.delete();
      rr_m = 0; last_w_m = 1'b1;
      #1;
      compared++;
      if ({gnt, sram_cs, sram_we, addr_err, rd_valid} !== 20'h0 || sram_addr !== 10'h0 || rd_data !== '0) begin
         mismatched++;
         $display("FAIL mid_clear cs=%b we=%b rv=%b addr=%h expected all 0", sram_cs, sram_we, rd_valid, sram_addr);
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      drain(4);
      req = 16'h0202; req_we = '0;
      req_addr[1] = mk_addr(BANK, 10'h011, 5'h0);
      req_addr[9] = mk_addr(BANK, 10'h019, 5'h0);
      run_cycle(g, p);
      compared++;
      if (g !== 16'h0002) begin mismatched++; $display("FAIL mid_restart gnt=%h expected 0002", g); end
      req[1] = 1'b0;
      run_cycle(g, p);
      compared++;
      if (g !== 16'h0200) begin mismatched++; $display("FAIL mid_next gnt=%h expected 0200", g); end
      drain(5);
   endtask

   task automatic test_enable();
      logic [15:0] g;
      int p;
      do_reset();
      en = 1'b0;
      set_idle();
      req = 16'h00FF;
      for (int i = 0; i < 8; i++) req_addr[i] = mk_addr(BANK, 10'(i * 3), 5'h0);
      for (int k = 0; k < 4; k++) begin
         run_cycle(g, p);
         compared++;
         if (g !== 16'h0) begin mismatched++; $display("FAIL en_off k=%0d gnt=%h expected 0000", k, g); end
      end
      en = 1'b1;
      run_cycle(g, p);
      compared++;
      if (g !== 16'h0001) begin mismatched++; $display("FAIL en_on gnt=%h expected 0001", g); end
      drain(5);
   endtask

   task automatic test_random();
      logic [15:0] g, g_exp;
      int p;
      for (int k = 0; k < 400; k++) begin
         en = ($urandom_range(0, 9) != 0);
         req = 16'($urandom);
         req_we = 16'($urandom);
         for (int i = 0; i < 16; i++) begin
            req_addr[i] = mk_addr(($urandom_range(0, 6) != 0) ? BANK : 4'($urandom),
                                  10'($urandom_range(0, 15)), 5'($urandom_range(0, 31)));
            req_wdata[i] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         end
         run_cycle(g, p);
         g_exp = (p >= 0) ? (16'h1 << p) : 16'h0;
         compared++;
         if (g !== g_exp) begin mismatched++; $display("FAIL rand_gnt k=%0d gnt=%h expected %h", k, g, g_exp); end
      end
      en = 1'b1;
      drain(8);
      compared++;
      if (exp_q.size() != 0) begin mismatched++; $display("FAIL drain_left pending=%0d expected 0", exp_q.size()); end
   endtask

   initial begin
      compared = 0;
      mismatched = 0;
      test_reset();
      test_first_read();
      test_all_reads();
      test_alternation();
      test_bank_mismatch();
      test_reset_mid();
      test_enable();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
